// File: rtl/coll_pkg.sv
// Shared types and helpers for the collision pair scheduler.
package coll_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      WAIT = 3'd2,
      NEXT = 3'd3,
      DONE = 3'd4
   } coll_state_t;

   localparam int COLL_TIMEOUT = 32'sd64;

   function automatic int pair_cnt(input int n);
      return (n * (n - 32'sd1)) / 32'sd2;
   endfunction

   // Index width of a pair number; kept at least 1 so a 2-object table still has a real bus.
   function automatic int pair_w(input int n);
      return (pair_cnt(n) > 32'sd1) ? $clog2(pair_cnt(n)) : 32'sd1;
   endfunction

endpackage

// File: rtl/coll_pair_iter.sv
// Walks (i,j) over all unordered pairs i<j of n objects and numbers them with p.
module coll_pair_iter
   import coll_pkg::*;
#(
   parameter int N_OBJ = 8,
   parameter int PW    = pair_w(N_OBJ),
   localparam int IW   = $clog2(N_OBJ),
   localparam int NW   = IW + 1
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic [NW-1:0] i_n,
   input  logic          i_init,
   input  logic          i_adv,
   output logic [IW-1:0] o_i,
   output logic [IW-1:0] o_j,
   output logic [PW-1:0] o_p,
   output logic          o_last
);

   logic [IW-1:0] r_i;
   logic [IW-1:0] r_j;
   logic [PW-1:0] r_p;
   logic          w_row_end;

   assign w_row_end = ({1'b0, r_j} == (i_n - NW'(1)));

   // Pair counters: restart on init, step to the next pair on adv.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_i <= '0;
         r_j <= '0;
         r_p <= '0;
      end else if (i_init) begin
         r_i <= IW'(0);
         r_j <= IW'(1);
         r_p <= PW'(0);
      end else if (i_adv) begin
         if (w_row_end) begin
            r_i <= r_i + IW'(1);
            r_j <= r_i + IW'(2);
         end else begin
            r_i <= r_i;
            r_j <= r_j + IW'(1);
         end
         r_p <= r_p + PW'(1);
      end else begin
         r_i <= r_i;
         r_j <= r_j;
         r_p <= r_p;
      end
   end

   assign o_i    = r_i;
   assign o_j    = r_j;
   assign o_p    = r_p;
   assign o_last = w_row_end && ({1'b0, r_i} == (i_n - NW'(2)));

endmodule

// File: rtl/coll_pair_sched.sv
// Pair scheduler: feeds every object pair through one shared coll_det and gathers hits.
// Define COLL_SCHED_TIMEOUT_EN to add the WAIT watchdog and the err output.
module coll_pair_sched
   import coll_pkg::*;
#(
   parameter int N_OBJ = 8,
   parameter int W     = 16,
   localparam int AW   = $clog2(N_OBJ),
   localparam int NW   = AW + 1,
   localparam int NP   = pair_cnt(N_OBJ),
   localparam int PW   = pair_w(N_OBJ),
   localparam int CW   = PW + 1
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_x,
   input  logic [W-1:0]  wr_y,
   input  logic [W-1:0]  wr_vx,
   input  logic [W-1:0]  wr_vy,
   input  logic [W-1:0]  r2,
   input  logic [NW-1:0] obj_cnt,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [NP-1:0] hit_vec,
   output logic [CW-1:0] hit_cnt,
   output logic [W-1:0]  det_x1,
   output logic [W-1:0]  det_y1,
   output logic [W-1:0]  det_vx1,
   output logic [W-1:0]  det_vy1,
   output logic [W-1:0]  det_x2,
   output logic [W-1:0]  det_y2,
   output logic [W-1:0]  det_vx2,
   output logic [W-1:0]  det_vy2,
   output logic [W-1:0]  det_r2,
   output logic          det_in_rdy,
   input  logic          det_out_rdy,
   input  logic          det_trial
`ifdef COLL_SCHED_TIMEOUT_EN
   ,
   output logic          err
`endif
);

   coll_state_t   r_state;
   coll_state_t   w_next;
   logic [W-1:0]  r_tx  [N_OBJ];
   logic [W-1:0]  r_ty  [N_OBJ];
   logic [W-1:0]  r_tvx [N_OBJ];
   logic [W-1:0]  r_tvy [N_OBJ];
   logic [NW-1:0] r_n;
   logic [NW-1:0] w_n_clamp;
   logic [AW-1:0] w_i;
   logic [AW-1:0] w_j;
   logic [PW-1:0] w_p;
   logic          w_last;
   logic          w_init;
   logic          w_adv;
   logic          w_accept;
   logic          w_hit_upd;
   logic          w_rise;
   logic          w_tmo;
   logic          w_scan;
   logic          r_out_rdy_q;
   logic          r_busy;
   logic          r_done;
   logic          r_in_rdy;
   logic [NP-1:0] r_hit_vec;
   logic [CW-1:0] r_hit_cnt;
   logic [W-1:0]  r_x1, r_y1, r_vx1, r_vy1;
   logic [W-1:0]  r_x2, r_y2, r_vx2, r_vy2;

   assign w_n_clamp = (obj_cnt > NW'(N_OBJ)) ? NW'(N_OBJ) : obj_cnt;
   assign w_rise    = det_out_rdy && !r_out_rdy_q;
   assign w_scan    = (r_state == LOAD) || (r_state == WAIT) || (r_state == NEXT);

   coll_pair_iter #(
      .N_OBJ (N_OBJ),
      .PW    (PW)
   ) u_iter (
      .clock  (clock),
      .rst_n  (rst_n),
      .i_n    (r_n),
      .i_init (w_init),
      .i_adv  (w_adv),
      .o_i    (w_i),
      .o_j    (w_j),
      .o_p    (w_p),
      .o_last (w_last)
   );

`ifdef COLL_SCHED_TIMEOUT_EN
   localparam int WDW = $clog2(COLL_TIMEOUT) + 1;
   logic [WDW-1:0] r_wdog;
   logic           r_err;

   // Watchdog: cycles spent in WAIT for the current pair.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         if (r_state == WAIT) begin
            r_wdog <= r_wdog + WDW'(1);
         end else begin
            r_wdog <= '0;
         end
         if (w_accept) begin
            r_err <= 1'b0;
         end else if (w_tmo) begin
            r_err <= 1'b1;
         end else begin
            r_err <= r_err;
         end
      end
   end

   assign w_tmo = (r_state == WAIT) && !w_rise && (r_wdog == WDW'(COLL_TIMEOUT - 1));
   assign err   = r_err;
`else
   assign w_tmo = 1'b0;
`endif

   // Next-state decode and iterator control.
   always_comb begin
      w_next    = r_state;
      w_init    = 1'b0;
      w_adv     = 1'b0;
      w_accept  = 1'b0;
      w_hit_upd = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               if (w_n_clamp < NW'(2)) begin
                  w_next = DONE;
               end else begin
                  w_next = LOAD;
                  w_init = 1'b1;
               end
            end else begin
               w_next = IDLE;
            end
         end
         LOAD: w_next = WAIT;
         WAIT: begin
            if (w_rise) begin
               w_hit_upd = 1'b1;
               w_next    = NEXT;
            end else if (w_tmo) begin
               w_next = DONE;
            end else begin
               w_next = WAIT;
            end
         end
         NEXT: begin
            if (w_last) begin
               w_next = DONE;
            end else begin
               w_next = LOAD;
               w_adv  = 1'b1;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Object table; writes are locked out while a scan is walking it.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_OBJ; k++) begin
            r_tx[k]  <= '0;
            r_ty[k]  <= '0;
            r_tvx[k] <= '0;
            r_tvy[k] <= '0;
         end
      end else if (wr_en && !w_scan) begin
         r_tx[wr_addr]  <= wr_x;
         r_ty[wr_addr]  <= wr_y;
         r_tvx[wr_addr] <= wr_vx;
         r_tvy[wr_addr] <= wr_vy;
      end
   end

   // FSM state, registered status outputs, results and detector operands.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_n         <= '0;
         r_out_rdy_q <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_in_rdy    <= 1'b0;
         r_hit_vec   <= '0;
         r_hit_cnt   <= '0;
         r_x1 <= '0; r_y1 <= '0; r_vx1 <= '0; r_vy1 <= '0;
         r_x2 <= '0; r_y2 <= '0; r_vx2 <= '0; r_vy2 <= '0;
      end else begin
         r_state     <= w_next;
         r_out_rdy_q <= det_out_rdy;
         r_busy      <= (w_next == LOAD) || (w_next == WAIT) || (w_next == NEXT);
         r_done      <= (w_next == DONE);
         r_in_rdy    <= (w_next == WAIT);
         if (w_accept) begin
            r_n       <= w_n_clamp;
            r_hit_vec <= '0;
            r_hit_cnt <= '0;
         end else if (w_hit_upd) begin
            r_hit_vec[w_p] <= det_trial;
            r_hit_cnt      <= r_hit_cnt + CW'(det_trial);
         end
         if (r_state == LOAD) begin
            r_x1 <= r_tx[w_i]; r_y1 <= r_ty[w_i]; r_vx1 <= r_tvx[w_i]; r_vy1 <= r_tvy[w_i];
            r_x2 <= r_tx[w_j]; r_y2 <= r_ty[w_j]; r_vx2 <= r_tvx[w_j]; r_vy2 <= r_tvy[w_j];
         end
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign det_in_rdy = r_in_rdy;
   assign hit_vec    = r_hit_vec;
   assign hit_cnt    = r_hit_cnt;
   assign det_x1     = r_x1;
   assign det_y1     = r_y1;
   assign det_vx1    = r_vx1;
   assign det_vy1    = r_vy1;
   assign det_x2     = r_x2;
   assign det_y2     = r_y2;
   assign det_vx2    = r_vx2;
   assign det_vy2    = r_vy2;
   assign det_r2     = r2;

endmodule

// File: tb/tb_coll_pair_sched.sv
// Scoreboard bench for coll_pair_sched with a behavioural detector responder.
module tb_coll_pair_sched;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = 3'd0;
   logic [15:0] wr_x = 16'd0, wr_y = 16'd0, wr_vx = 16'd0, wr_vy = 16'd0;
   logic [15:0] r2 = 16'd100;
   logic [3:0]  obj_cnt = 4'd0;
   logic        start = 1'b0;
   logic        det_out_rdy = 1'b0;
   logic        det_trial = 1'b0;
   wire         busy, done, det_in_rdy, w_err;
   wire  [27:0] hit_vec;
   wire  [5:0]  hit_cnt;
   wire  [15:0] det_x1, det_y1, det_vx1, det_vy1, det_x2, det_y2, det_vx2, det_vy2, det_r2;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int m_cnt = 0;
   int m_lat = 3;
   int m_wid = 1;
   bit hit_tbl [16][16];
   bit mute_en = 1'b0;
   logic [127:0] q_ops[$];
   logic [34:0]  q_res[$];
   logic         prev_rdy = 1'b0;

`ifdef COLL_SCHED_TIMEOUT_EN
   wire err;
   assign w_err = err;
`else
   assign w_err = 1'b0;
`endif

   coll_pair_sched #(.N_OBJ(8), .W(16)) dut (
      .clock(clock), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_x(wr_x), .wr_y(wr_y), .wr_vx(wr_vx), .wr_vy(wr_vy), .r2(r2),
      .obj_cnt(obj_cnt), .start(start), .busy(busy), .done(done),
      .hit_vec(hit_vec), .hit_cnt(hit_cnt),
      .det_x1(det_x1), .det_y1(det_y1), .det_vx1(det_vx1), .det_vy1(det_vy1),
      .det_x2(det_x2), .det_y2(det_y2), .det_vx2(det_vx2), .det_vy2(det_vy2),
      .det_r2(det_r2), .det_in_rdy(det_in_rdy), .det_out_rdy(det_out_rdy),
      .det_trial(det_trial)
`ifdef COLL_SCHED_TIMEOUT_EN
      , .err(err)
`endif
   );

   always #5 clock = ~clock;

   task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] obj_bits(input int k);
      return {16'(k), 16'h1000 + 16'(k), 16'h2000 + 16'(k), 16'h3000 + 16'(k)};
   endfunction

   // Detector stand-in: reply m_lat cycles after in_rdy rises, pulse m_wid cycles wide.
   always @(posedge clock) begin
      if (!det_in_rdy) begin
         m_cnt       <= 0;
         det_out_rdy <= 1'b0;
         det_trial   <= 1'b0;
      end else begin
         m_cnt <= m_cnt + 1;
         if (m_cnt >= m_lat && m_cnt < m_lat + m_wid &&
             !(mute_en && det_x1 == 16'd0 && det_x2 == 16'd2)) begin
            det_out_rdy <= 1'b1;
            det_trial   <= hit_tbl[det_x1[3:0]][det_x2[3:0]];
         end else begin
            det_out_rdy <= 1'b0;
            det_trial   <= 1'b0;
         end
      end
   end

   // Monitor: operand scoreboard on each new detector request, result scoreboard on done.
   always @(negedge clock) begin
      logic [127:0] e_ops;
      logic [34:0]  e_res;
      if (det_in_rdy && !prev_rdy) begin
         if (q_ops.size() == 0) begin
            chk(1'b0, "unexpected_in_rdy", 128'd1, 128'd0);
         end else begin
            e_ops = q_ops.pop_front();
            chk({det_x1, det_y1, det_vx1, det_vy1, det_x2, det_y2, det_vx2, det_vy2} == e_ops, "operands",
                {det_x1, det_y1, det_vx1, det_vy1, det_x2, det_y2, det_vx2, det_vy2}, e_ops);
         end
      end
      prev_rdy = det_in_rdy;
      if (done) begin
         done_cnt++;
         chk(busy == 1'b0, "busy_at_done", 128'(busy), 128'd0);
         if (q_res.size() == 0) begin
            chk(1'b0, "unexpected_done", 128'd1, 128'd0);
         end else begin
            e_res = q_res.pop_front();
            chk({hit_vec, hit_cnt, w_err} == e_res, "result_vec_cnt_err",
                128'({hit_vec, hit_cnt, w_err}), 128'(e_res));
         end
      end
   end

   task automatic clr_tbl();
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            hit_tbl[a][b] = 1'b0;
   endtask

   task automatic write_objs(input int cnt);
      for (int k = 0; k < cnt; k++) begin
         @(negedge clock);
         wr_en = 1'b1; wr_addr = 3'(k);
         {wr_x, wr_y, wr_vx, wr_vy} = obj_bits(k);
      end
      @(negedge clock);
      wr_en = 1'b0;
   endtask

   // Queue expected operands for the first n_pres pairs and the final result, then pulse start.
   task automatic kick(input int n_req, input int n_pres, input logic [27:0] ev,
                       input logic [5:0] ec, input logic ee);
      int n;
      int cnt;
      n = (n_req > 8) ? 8 : n_req;
      cnt = 0;
      for (int i = 0; i < n; i++)
         for (int j = i + 1; j < n; j++) begin
            if (cnt < n_pres) q_ops.push_back({obj_bits(i), obj_bits(j)});
            cnt++;
         end
      q_res.push_back({ev, ec, ee});
      @(negedge clock);
      obj_cnt = 4'(n_req);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, input string nm);
      int c;
      c = 0;
      while (done_cnt == d0 && c < budget) begin
         @(negedge clock);
         c++;
      end
      chk(done_cnt != d0, nm, 128'(c), 128'(budget));
   endtask

   task automatic wait_in_rdy(input int budget);
      int c;
      c = 0;
      while (!det_in_rdy && c < budget) begin
         @(negedge clock);
         c++;
      end
      chk(det_in_rdy == 1'b1, "in_rdy_timeout", 128'(det_in_rdy), 128'd1);
   endtask

   initial begin
      int d0;
      int rises;
      int wid;
      logic pv;
      clr_tbl();
      repeat (3) @(negedge clock);
      chk({busy, done, det_in_rdy} == 3'b000, "reset_flags", 128'({busy, done, det_in_rdy}), 128'd0);
      chk(hit_vec == 28'd0 && hit_cnt == 6'd0, "reset_hits", 128'({hit_vec, hit_cnt}), 128'd0);
      chk({det_x1, det_vy2} == 32'd0, "reset_operands", 128'({det_x1, det_vy2}), 128'd0);
      rst_n = 1'b1;

      // Three objects, only pair (0,2) collides.
      write_objs(3);
      hit_tbl[0][2] = 1'b1;
      d0 = done_cnt;
      kick(3, 3, 28'b010, 6'd1, 1'b0);
      wait_done(d0, 200, "done_3obj");

      // Four objects, 3-cycle-wide replies; hits on (0,3),(1,2),(2,3) -> p 2,3,5.
      clr_tbl();
      write_objs(4);
      hit_tbl[0][3] = 1'b1; hit_tbl[1][2] = 1'b1; hit_tbl[2][3] = 1'b1;
      m_wid = 3;
      d0 = done_cnt;
      kick(4, 6, 28'h000002C, 6'd3, 1'b0);
      wait_done(d0, 300, "done_4obj");
      m_wid = 1;

      // Single object: immediate done, no detector request.
      d0 = done_cnt;
      kick(1, 0, 28'd0, 6'd0, 1'b0);
      wait_done(d0, 2, "done_1obj_latency");

      // obj_cnt above the table depth clamps to 8 objects, 28 pairs; hits p 0,19,27.
      clr_tbl();
      write_objs(8);
      hit_tbl[0][1] = 1'b1; hit_tbl[3][5] = 1'b1; hit_tbl[6][7] = 1'b1;
      d0 = done_cnt;
      kick(11, 28, 28'h8080001, 6'd3, 1'b0);
      wait_done(d0, 600, "done_clamped");

      // Start and write while busy are ignored; rescan shows the original object 1.
      clr_tbl();
      d0 = done_cnt;
      kick(3, 3, 28'd0, 6'd0, 1'b0);
      wait_in_rdy(10);
      @(negedge clock);
      start = 1'b1; obj_cnt = 4'd8;
      wr_en = 1'b1; wr_addr = 3'd1; {wr_x, wr_y, wr_vx, wr_vy} = {16'd15, 16'hAAAA, 16'hBBBB, 16'hCCCC};
      @(negedge clock);
      start = 1'b0; wr_en = 1'b0;
      wait_done(d0, 200, "done_busy_ignore");
      hit_tbl[1][2] = 1'b1;
      d0 = done_cnt;
      kick(3, 3, 28'b100, 6'd1, 1'b0);
      wait_done(d0, 200, "done_readback");

      // Reset while waiting on pair 1 after pair 0 has hit.
      clr_tbl();
      hit_tbl[0][1] = 1'b1;
      kick(3, 3, 28'b001, 6'd1, 1'b0);
      rises = 0; pv = 1'b0;
      for (int c = 0; c < 60 && rises < 2; c++) begin
         @(negedge clock);
         if (det_in_rdy && !pv) rises++;
         pv = det_in_rdy;
      end
      chk(rises == 2, "reach_pair1", 128'(rises), 128'd2);
      chk(hit_vec == 28'd1 && hit_cnt == 6'd1, "pre_reset_hits", 128'({hit_vec, hit_cnt}), 128'({28'd1, 6'd1}));
      @(posedge clock);
      #1 rst_n = 1'b0;
      #1;
      chk({busy, done, det_in_rdy} == 3'b000, "midreset_flags", 128'({busy, done, det_in_rdy}), 128'd0);
      chk(hit_vec == 28'd0 && hit_cnt == 6'd0, "midreset_hits", 128'({hit_vec, hit_cnt}), 128'd0);
      chk(det_x2 == 16'd0, "midreset_operand", 128'(det_x2), 128'd0);
      q_ops.delete();
      q_res.delete();
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      write_objs(3);
      clr_tbl();
      hit_tbl[1][2] = 1'b1;
      d0 = done_cnt;
      kick(3, 3, 28'b100, 6'd1, 1'b0);
      wait_done(d0, 200, "done_after_reset");

`ifdef COLL_SCHED_TIMEOUT_EN
      // Detector never answers pair 1: 64 WAIT cycles then done with err and bit 0 kept.
      clr_tbl();
      hit_tbl[0][1] = 1'b1;
      mute_en = 1'b1;
      d0 = done_cnt;
      kick(3, 2, 28'b001, 6'd1, 1'b1);
      rises = 0; wid = 0; pv = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         if (det_in_rdy && !pv) rises++;
         if (rises == 2 && det_in_rdy) wid++;
         if (rises == 2 && !det_in_rdy) break;
         pv = det_in_rdy;
      end
      chk(wid == 64, "timeout_wait_cycles", 128'(wid), 128'd64);
      wait_done(d0, 5, "done_timeout");
      chk(w_err == 1'b1, "err_held", 128'(w_err), 128'd1);
      mute_en = 1'b0;
      d0 = done_cnt;
      kick(3, 3, 28'b001, 6'd1, 1'b0);
      wait_done(d0, 200, "done_err_clear");
`endif

      repeat (3) @(negedge clock);
      chk(q_ops.size() == 0, "ops_queue_drained", 128'(q_ops.size()), 128'd0);
      chk(q_res.size() == 0, "res_queue_drained", 128'(q_res.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=%0d expected=%0d", checks, 0);
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/coll_pair_sched.md
# coll_pair_sched

Pair scheduler for the two-circle collision detector. It holds a small table of object states (position, velocity). On `start` it walks every unordered pair (i<j) of the first `obj_cnt` objects through a single shared `coll_det` instance, one pair at a time, using that detector's `in_rdy`/`out_rdy` handshake. Per-pair results are collected into a hit vector plus a hit count, and completion is signalled with `done`.

## Interface
- `N_OBJ`, 8: object table depth; legal range 2..16.
- `W`, 16: coordinate/velocity width; must match the detector's operand width.
- `PW`, derived: pair-index width, clog2(N_OBJ*(N_OBJ-1)/2).
- `clock` in 1: single system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: object-table write strobe.
- `wr_addr` in clog2(N_OBJ): table entry written.
- `wr_x`, `wr_y`, `wr_vx`, `wr_vy` in W each: object position and velocity.
- `r2` in W: radius-squared operand. Passed straight to the detector and must be held stable while `busy`.
- `obj_cnt` in clog2(N_OBJ)+1: number of active objects; latched at `start`.
- `start` in 1: one-cycle request to begin a scan.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse when the scan ends.
- `hit_vec` out N_OBJ*(N_OBJ-1)/2: bit p set = pair p collides.
- `hit_cnt` out PW+1: number of set bits in `hit_vec`.
- `det_x1`, `det_y1`, `det_vx1`, `det_vy1`, `det_x2`, `det_y2`, `det_vx2`, `det_vy2` out W each: detector operands.
- `det_in_rdy` out 1: detector run enable.
- `det_out_rdy` in 1: detector result strobe.
- `det_trial` in 1: detector collision result.
- `err` out 1: timeout abort flag (present only with the macro in Configuration).

## Operation
- **Reset values:**
  - `busy`, `done`, `det_in_rdy` and `err` are 0.
  - `hit_vec` and `hit_cnt` are 0.
  - All `det_*` operands are 0.
  - The object table is all zeros.
  - FSM is in IDLE.
- **Pair order:** (0,1),(0,2)…(0,n-1),(1,2)…(n-2,n-1). Pair index p increments by 1 per pair, starting at 0.
- **FSM:**
  - IDLE: on `start`, latch `obj_cnt` as n. If n<2, go to DONE with zero hits. Otherwise clear `hit_vec` and `hit_cnt`, set i=0, j=1, p=0, and go to LOAD.
  - LOAD: drive the operands from table[i] and table[j]; `det_in_rdy`=0. Go to WAIT.
  - WAIT: `det_in_rdy`=1; the operands are held constant. On a rising edge of `det_out_rdy` (high now, low in the previous cycle), set `hit_vec[p]` = `det_trial` sampled in that same cycle, add `det_trial` to `hit_cnt`, and go to NEXT.
  - NEXT: `det_in_rdy`=0. If (i,j) is the last pair, go to DONE. Otherwise advance: j++, or if j==n-1 then i++ and j=i+1; p++. Go to LOAD.
  - DONE: `done`=1 for one cycle, `busy`=0, go to IDLE.
- `busy` is 1 in LOAD, WAIT and NEXT.
- `hit_vec` and `hit_cnt` hold their values until the next accepted `start`.
- **Ignored inputs:**
  - `det_out_rdy` edges outside WAIT.
  - `start` while busy.
  - `wr_en` while busy (no table update).
- **Range limits:**
  - `obj_cnt` > N_OBJ is clamped to N_OBJ.
  - Bits of `hit_vec` at or above n(n-1)/2 stay 0.
- **Reset during a scan:** abandon immediately; all outputs return to their reset values, and the table is cleared.

## Timing
- Table write: visible from the cycle after `wr_en`.
- `start` to first `det_in_rdy` high: 2 cycles (IDLE→LOAD→WAIT).
- Per pair: 1 (LOAD) + detector latency + 1 (NEXT). With a 10-cycle detector, an 8-object scan of 28 pairs completes in about 340 cycles.
- `done` asserts 1 cycle after the final NEXT. `hit_vec` and `hit_cnt` are valid in that same cycle.
- `det_in_rdy` drops for 2 cycles (NEXT, LOAD) between pairs, which restarts the detector's internal sequence cleanly.

## Configuration
- `COLL_SCHED_TIMEOUT_EN` defined: a watchdog counts cycles spent in WAIT. If it reaches `COLL_TIMEOUT` (64) without a `det_out_rdy` edge:
  - `det_in_rdy` drops, `err` sets, and the FSM goes to DONE with the partial `hit_vec`.
  - `err` clears on the next accepted `start`.
- Undefined: no watchdog and no `err` port; WAIT blocks indefinitely.

## Structure
- Package `coll_pkg` holds:
  - the state enum (IDLE, LOAD, WAIT, NEXT, DONE);
  - `COLL_TIMEOUT`;
  - a pair-count function n(n-1)/2 used for the `hit_vec` and `PW` widths.
- Sub-module `coll_pair_iter`: owns the i/j/p counters. It takes n, `init` and `adv` inputs and produces i, j, p and `last`.
- The object table is a flat register array inside `coll_pair_sched`.

## Test plan
- **Full scan, one hit:** write 3 objects; the detector model returns `trial`=1 only for pair (0,2). Scan → `hit_vec`=3'b010, `hit_cnt`=1, `done` after 3 pairs.
- **Pair ordering:** `obj_cnt`=4. Check the operand sequence (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) and that `hit_vec` bit p matches each model result.
- **Degenerate counts:**
  - `obj_cnt`=1 → `done` 2 cycles after `start`, `hit_vec`=0, no `det_in_rdy`.
  - `obj_cnt`=N_OBJ+3 → clamped to N_OBJ, 28 pairs.
- **Ignored inputs while busy:** a `start` and a `wr_en` mid-scan are ignored, and table readback after `done` shows the old value. A 3-cycle-wide `det_out_rdy` is counted once.
- **Reset mid-scan:** assert `rst_n`=0 in WAIT → `busy`, `det_in_rdy`, `hit_vec` and `hit_cnt` are all 0 immediately; a fresh scan then completes normally.
- **Timeout (`COLL_SCHED_TIMEOUT_EN`):** the detector model never responds on pair 1 → `err`=1 and `done` after 64 WAIT cycles, `hit_vec` bit 0 retained.
